// File: rtl/mem_port_arbiter_pkg.sv
// Shared constants for the two-port memory arbiter: port indices and memory read latency.
package mem_port_arbiter_pkg;
    localparam logic PORT_CPU    = 1'b0;
    localparam logic PORT_PERIPH = 1'b1;
    localparam int   RD_LAT      = 1;
endpackage

// File: rtl/mem_port_arbiter_rr_pick2.sv
// Two-way round-robin picker; an active lock keeps the grant on port 1 during contention.
module rr_pick2
    import mem_port_arbiter_pkg::*;
(
    input  logic       req0,
    input  logic       req1,
    input  logic       last_owner,
    input  logic       lock_active,
    output logic [1:0] gnt
);
    logic both;

    assign both = req0 & req1;

    // On a tie the port that did not win last time goes next, unless port 1 holds the lock.
    assign gnt[0] = req0 & (~req1 | (~lock_active & (last_owner == PORT_PERIPH)));
    assign gnt[1] = req1 & (~req0 | (both & (lock_active | (last_owner == PORT_CPU))));
endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the CPU (port 0) and a peripheral master (port 1),
// tagging reads so the returned word is routed back to the requester that issued it.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int MAX_LOCK = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,
    output logic              gnt0,
    output logic              rvalid0,
    input  logic              req1,
    input  logic              we1,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt1,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int              CNT_W    = $clog2(MAX_LOCK + 1);
    localparam logic [CNT_W-1:0] LOCK_MAX = CNT_W'(MAX_LOCK);

    logic             last_owner;
    logic [CNT_W-1:0] lock_cnt;
    logic             tag_vld;
    logic             tag_own;
    logic             lock_active;
    logic [1:0]       pick;

    assign lock_active = (last_owner == PORT_PERIPH) & lock1 & (lock_cnt < LOCK_MAX);

    rr_pick2 u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_owner  (last_owner),
        .lock_active (lock_active),
        .gnt         (pick)
    );

    // Grants are combinational, so they must be masked while reset is held.
    assign gnt0   = pick[0] & ~Reset;
    assign gnt1   = pick[1] & ~Reset;
    assign mem_en = gnt0 | gnt1;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (gnt0) begin
            mem_we    = we0;
            mem_addr  = addr0;
            mem_wdata = wdata0;
        end else if (gnt1) begin
            mem_we    = we1;
            mem_addr  = addr1;
            mem_wdata = wdata1;
        end
    end

    assign rvalid0 = tag_vld & (tag_own == PORT_CPU);
    assign rvalid1 = tag_vld & (tag_own == PORT_PERIPH);
    assign rdata   = tag_vld ? mem_rdata : '0;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            last_owner <= PORT_PERIPH;
            lock_cnt   <= '0;
            tag_vld    <= 1'b0;
            tag_own    <= PORT_CPU;
        end else begin
            if (mem_en)
                last_owner <= gnt1;
            // With no contender the count holds, so an uncontested lock never expires.
            if (gnt1 && lock1 && req0) begin
                if (lock_cnt != LOCK_MAX)
                    lock_cnt <= lock_cnt + 1'b1;
            end else if (gnt0 || (gnt1 && !lock1)) begin
                lock_cnt <= '0;
            end
            tag_vld <= mem_en & ~mem_we;
            tag_own <= gnt1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: grant checks inline, read returns via a scoreboard queue.
module tb_mem_port_arbiter;
    logic        Clock = 1'b0;
    logic        Reset;
    logic        req0, we0, req1, we1, lock1;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_en, mem_we;

    typedef struct { logic port; logic [15:0] data; } rd_exp_t;
    rd_exp_t exp_q[$];
    int errs = 0;
    int chks = 0;
    logic [15:0] mem [0:255];

    always #5 Clock = ~Clock;

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MAX_LOCK(4)) dut (
        .Clock(Clock), .Reset(Reset),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .gnt0(gnt0), .rvalid0(rvalid0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1), .gnt1(gnt1),
        .rvalid1(rvalid1), .rdata(rdata), .mem_en(mem_en), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Synchronous block RAM model, 256 words, preloaded with 0x1000 + index.
    initial for (int i = 0; i < 256; i++) mem[i] = 16'h1000 + 16'(i);
    always @(posedge Clock) begin
        if (mem_en && mem_we) mem[mem_addr[7:0]] <= mem_wdata;
        if (mem_en && !mem_we) mem_rdata <= mem[mem_addr[7:0]];
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        chks++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
        end
    endtask

    // Monitor: every rvalid pops the oldest expected read and compares owner and data.
    always @(negedge Clock) begin
        if (rvalid0 || rvalid1) begin
            chks++;
            if (exp_q.size() == 0) begin
                errs++;
                $display("FAIL unexpected_rvalid: rvalid0=%b rvalid1=%b rdata=%h at %0t",
                         rvalid0, rvalid1, rdata, $time);
            end else begin
                rd_exp_t e;
                e = exp_q.pop_front();
                if (rvalid0 !== !e.port || rvalid1 !== e.port || rdata !== e.data) begin
                    errs++;
                    $display("FAIL read_return: rvalid0=%b rvalid1=%b rdata=%h expected port%0d data %h at %0t",
                             rvalid0, rvalid1, rdata, e.port, e.data, $time);
                end
            end
        end
    end

    // One cycle: inputs are already driven; check grants at negedge, queue expected read data.
    task automatic step(input logic eg0, input logic eg1, input logic [15:0] erd, input string nm);
        @(negedge Clock);
        check({nm, "_gnt"}, {30'd0, gnt0, gnt1}, {30'd0, eg0, eg1});
        check({nm, "_mem_en"}, {31'd0, mem_en}, {31'd0, eg0 | eg1});
        if (eg0 || eg1) begin
            check({nm, "_mem_addr"}, {16'd0, mem_addr}, {16'd0, eg0 ? addr0 : addr1});
            check({nm, "_mem_we"}, {31'd0, mem_we}, {31'd0, eg0 ? we0 : we1});
            if (eg0 ? we0 : we1)
                check({nm, "_mem_wdata"}, {16'd0, mem_wdata}, {16'd0, eg0 ? wdata0 : wdata1});
            else
                exp_q.push_back('{port: eg1, data: erd});
        end
        @(posedge Clock); #1;
    endtask

    task automatic idle();
        req0 = 0; req1 = 0; lock1 = 0; we0 = 0; we1 = 0;
    endtask

    task automatic do_reset();
        Reset = 1;
        @(negedge Clock);
        check("rst_gnt", {30'd0, gnt0, gnt1}, 32'd0);
        check("rst_mem", {14'd0, mem_en, mem_we, mem_addr}, 32'd0);
        check("rst_rvalid", {14'd0, rvalid0, rvalid1, rdata}, 32'd0);
        check("rst_wdata", {16'd0, mem_wdata}, 32'd0);
        @(posedge Clock); #1;
        Reset = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1; idle();
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
        @(posedge Clock); #1;
        req0 = 1; req1 = 1; // requests present during reset must not be granted
        do_reset();
        idle();

        // Single CPU read.
        req0 = 1; addr0 = 16'h0010;
        step(1, 0, 16'h1010, "cpu_read");
        idle();
        step(0, 0, 16'h0, "idle1");

        // Tie without lock after reset: strict alternation starting with the CPU.
        do_reset();
        req0 = 1; req1 = 1; addr0 = 16'h0011; addr1 = 16'h0040;
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0) begin
                step(1, 0, 16'h1000 + addr0, "alt_cpu");
                addr0++;
            end else begin
                step(0, 1, 16'h1000 + addr1, "alt_per");
                addr1++;
            end
        end
        idle();
        step(0, 0, 16'h0, "idle2");

        // Lock already held, then CPU contends: 4 more port-1 grants, CPU on the 5th.
        req1 = 1; lock1 = 1; addr1 = 16'h0050;
        step(0, 1, 16'h1050, "lock_first");
        addr1++;
        req0 = 1; addr0 = 16'h0014;
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 16'h1000 + addr1, "lock_hold");
            addr1++;
        end
        step(1, 0, 16'h1014, "lock_expire");
        idle();
        step(0, 0, 16'h0, "idle3");

        // Port-1 write then CPU read of the same word.
        req1 = 1; we1 = 1; addr1 = 16'h0020; wdata1 = 16'hBEEF;
        step(0, 1, 16'h0, "per_write");
        idle();
        req0 = 1; addr0 = 16'h0020;
        step(1, 0, 16'hBEEF, "cpu_readback");
        idle();
        step(0, 0, 16'h0, "idle4");

        // Reset right after a granted read: the return is dropped.
        req0 = 1; addr0 = 16'h0010;
        @(negedge Clock);
        check("drop_gnt", {30'd0, gnt0, gnt1}, 32'd2);
        @(posedge Clock); #1;
        idle();
        Reset = 1;
        @(negedge Clock);
        check("drop_rvalid", {30'd0, rvalid0, rvalid1}, 32'd0);
        @(posedge Clock); #1;
        Reset = 0;
        req0 = 1; req1 = 1; addr0 = 16'h0030; addr1 = 16'h0031;
        step(1, 0, 16'h1030, "post_rst_tie");
        req0 = 0;
        step(0, 1, 16'h1031, "post_rst_p1");
        idle();
        step(0, 0, 16'h0, "idle5");

        // Uncontested lock for 10 cycles, then CPU gets in within MAX_LOCK+1 cycles.
        req1 = 1; lock1 = 1; addr1 = 16'h0060;
        for (int k = 0; k < 10; k++) begin
            step(0, 1, 16'h1000 + addr1, "lock_alone");
            addr1++;
        end
        req0 = 1; addr0 = 16'h0015;
        for (int k = 0; k < 4; k++) begin
            step(0, 1, 16'h1000 + addr1, "lock_alone_hold");
            addr1++;
        end
        step(1, 0, 16'h1015, "lock_alone_expire");
        idle();
        step(0, 0, 16'h0, "idle6");
        step(0, 0, 16'h0, "idle7");

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errs, chks);
        $finish;
    end
endmodule
